// File: rtl/ascon_perm_sequencer.sv
// Ascon permutation round sequencer: one p12 or p8 run per request.
// It walks the round index and derives the round constant from it.
// A per-round enable follows datapath backpressure, and a one-cycle done
// pulse marks the end of a run.
module ascon_perm_sequencer #(
  parameter logic [3:0] P12_START = 4'h4,
  parameter logic [3:0] P8_START  = 4'h8,
  parameter logic [3:0] LAST_RND  = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       dp_ready,
  output logic       busy,
  output logic       round_en,
  output logic [3:0] rnd,
  output logic [7:0] rc,
  output logic       first_round,
  output logic       last_round,
  output logic       done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [3:0] rnd_r;
  logic [3:0] rnd_s;
  logic       mode_r;
  logic       mode_s;
  logic       done_r;
  logic       done_s;
  logic [3:0] first_rnd_s;

  // Round constant: the low nibble counts rounds from the p12 origin and
  // the high nibble is its complement, so both modes share one table.
  function automatic logic [7:0] round_const(input logic [3:0] r);
    logic [3:0] idx;
    idx = r - P12_START;
    return {4'hF - idx, idx};
  endfunction

  // First round index of the permutation currently held in mode_r.
  always_comb begin
    if (mode_r) begin
      first_rnd_s = P12_START;
    end else begin
      first_rnd_s = P8_START;
    end
  end

  // Next-state, next-round and done-pulse decision.
  always_comb begin
    state_s = state_r;
    rnd_s   = rnd_r;
    mode_s  = mode_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          mode_s  = mode;
          rnd_s   = mode ? P12_START : P8_START;
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (rnd_r < first_rnd_s) begin
          // Corrupted index: abandon the run without reporting completion.
          state_s = ST_IDLE;
        end else if (!dp_ready) begin
          state_s = ST_RUN;
        end else if (rnd_r == LAST_RND) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          rnd_s = rnd_r + 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, round index, captured mode and done pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      rnd_r   <= P12_START;
      mode_r  <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      rnd_r   <= rnd_s;
      mode_r  <= mode_s;
      done_r  <= done_s;
    end
  end

  // Outputs decoded from the registered state and round index.
  always_comb begin
    busy        = (state_r == ST_RUN);
    round_en    = (state_r == ST_RUN) && dp_ready;
    rnd         = rnd_r;
    rc          = round_const(rnd_r);
    first_round = (state_r == ST_RUN) && (rnd_r == first_rnd_s);
    last_round  = (state_r == ST_RUN) && (rnd_r == LAST_RND);
    done        = done_r;
  end

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Self-checking bench for ascon_perm_sequencer: directed scenarios with
// literal expectations plus randomized traffic against a round-count model.
module tb_ascon_perm_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       dp_ready = 1'b0;
  logic       busy;
  logic       round_en;
  logic [3:0] rnd;
  logic [7:0] rc;
  logic       first_round;
  logic       last_round;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  ascon_perm_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .dp_ready(dp_ready),
    .busy(busy), .round_en(round_en), .rnd(rnd), .rc(rc),
    .first_round(first_round), .last_round(last_round), .done(done)
  );

  always #5 clk = ~clk;

  // Model: a permutation is "active" with a count of rounds already executed.
  bit m_active   = 1'b0;
  bit m_mode     = 1'b1;
  int m_count    = 0;
  bit m_done     = 1'b0;
  int m_idle_rnd = 4;

  function automatic int nrounds(input bit md);
    return md ? 12 : 8;
  endfunction

  function automatic int first_of(input bit md);
    return md ? 4 : 8;
  endfunction

  function automatic logic [7:0] rc_of(input int r);
    case (r)
      4: return 8'hF0;   5: return 8'hE1;   6: return 8'hD2;   7: return 8'hC3;
      8: return 8'hB4;   9: return 8'hA5;  10: return 8'h96;  11: return 8'h87;
      12: return 8'h78; 13: return 8'h69;  14: return 8'h5A;  15: return 8'h4B;
      default: return 8'h00;
    endcase
  endfunction

  // Model update on each rising edge from the inputs held during the cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_mode = 1'b1; m_count = 0; m_done = 1'b0; m_idle_rnd = 4;
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1; m_mode = mode; m_count = 0;
        end
      end else if (dp_ready) begin
        m_count = m_count + 1;
        if (m_count == nrounds(m_mode)) begin
          m_active = 1'b0; m_done = 1'b1; m_idle_rnd = 15;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int          er;
    logic [16:0] exp_v;
    logic [16:0] act_v;
    logic [3:0]  er4;
    if (chk_en) begin
      er    = m_active ? first_of(m_mode) + m_count : m_idle_rnd;
      er4   = er[3:0];
      exp_v = {m_active, m_active && dp_ready, er4, rc_of(er),
               m_active && (m_count == 0), m_active && (er == 15), m_done};
      act_v = {busy, round_en, rnd, rc, first_round, last_round, done};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t {busy,en,rnd,rc,first,last,done} got=%h want=%h",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Run one permutation starting in the current cycle (cycle 0); stall dp_ready
  // over cycles st_lo..st_hi; with hold set, start stays high (mode 0) throughout.
  task automatic run_perm(input bit md, input int st_lo, input int st_hi, input bit hold,
                          output int en_cnt, output int done_cyc,
                          output logic [3:0] rnd_at, output logic [7:0] rc_first);
    en_cnt = 0; done_cyc = -1; rnd_at = 4'h0; rc_first = 8'h00;
    start = 1'b1; mode = md; dp_ready = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      start    = hold;
      mode     = hold ? 1'b0 : md;
      dp_ready = (c >= st_lo && c <= st_hi) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == 1) rc_first = rc;
      if (round_en) en_cnt++;
      if (c == st_hi) rnd_at = rnd;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  initial begin
    int         en_cnt;
    int         dcyc;
    int         d2;
    bit         seen;
    logic [3:0] rat;
    logic [7:0] rcf;

    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    @(negedge clk);
    chk("reset_outputs", {busy, round_en, rnd, rc, first_round, last_round, done},
        {1'b0, 1'b0, 4'h4, 8'hF0, 1'b0, 1'b0, 1'b0});
    cyc();
    rst = 1'b0; dp_ready = 1'b1;
    cyc();

    // p12, no stalls
    run_perm(1'b1, 100, 0, 1'b0, en_cnt, dcyc, rat, rcf);
    chk("p12_en_count", en_cnt, 12);
    chk("p12_done_cycle", dcyc, 13);
    chk("p12_rc_first", rcf, 8'hF0);
    chk("p12_busy_at_done", busy, 1'b0);
    cyc();

    // p8, no stalls
    run_perm(1'b0, 100, 0, 1'b0, en_cnt, dcyc, rat, rcf);
    chk("p8_en_count", en_cnt, 8);
    chk("p8_done_cycle", dcyc, 9);
    chk("p8_rc_first", rcf, 8'hB4);

    // idle hold after p8
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      chk("idle_hold", {rnd, round_en, done}, {4'hF, 1'b0, 1'b0});
    end

    // p12 with stall over cycles 3..5
    cyc();
    run_perm(1'b1, 3, 5, 1'b0, en_cnt, dcyc, rat, rcf);
    chk("stall_en_count", en_cnt, 12);
    chk("stall_done_cycle", dcyc, 16);
    chk("stall_rnd_held", rat, 4'h6);

    // ignored start during RUN, then back-to-back p8 accepted in the done cycle
    cyc();
    run_perm(1'b1, 100, 0, 1'b1, en_cnt, dcyc, rat, rcf);
    chk("ign_en_count", en_cnt, 12);
    chk("ign_done_cycle", dcyc, 13);
    cyc();
    start = 1'b0;
    @(negedge clk);
    chk("b2b_first", {busy, rnd, rc, first_round}, {1'b1, 4'h8, 8'hB4, 1'b1});
    d2 = -1;
    for (int c = 2; c <= 20; c++) begin
      cyc();
      @(negedge clk);
      if (done) begin
        d2 = c;
        break;
      end
    end
    chk("b2b_done_after_accept", d2, 9);

    // reset mid-permutation at rnd 9
    cyc();
    start = 1'b1; mode = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) cyc();
      @(negedge clk);
    end
    chk("rst_pre_rnd", rnd, 4'h9);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {busy, rnd, rc, done}, {1'b0, 4'h4, 8'hF0, 1'b0});
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("rst_no_done", seen, 1'b0);
    cyc();
    run_perm(1'b1, 100, 0, 1'b0, en_cnt, dcyc, rat, rcf);
    chk("post_rst_done_cycle", dcyc, 13);

    // randomized traffic, checked cycle by cycle by the model
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst      = ($urandom_range(299, 0) == 0);
      start    = ($urandom_range(2, 0) == 0);
      mode     = $urandom_range(1, 0);
      dp_ready = ($urandom_range(3, 0) != 0);
    end
    cyc();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ascon_perm_sequencer.md
Name: ascon_perm_sequencer

Overview:
- Drives an Ascon permutation datapath through one p12 or p8 permutation per request.
- Accepts a start/mode request from the AEAD mode FSM and sequences the round index.
- Derives the 8-bit round constant and issues a per-round enable to the datapath, with datapath backpressure.
- Signals completion to the requester with a one-cycle done pulse.

Parameters:
- P12_START, 4'h4, round index of the first p12 round (12 rounds: 4..15).
- P8_START, 4'h8, round index of the first p8 round (8 rounds: 8..15).
- LAST_RND, 4'hF, round index of the final round for both modes.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request one permutation; sampled only in IDLE
- mode  in  1  1 = p12, 0 = p8; sampled with start
- dp_ready  in  1  datapath can execute a round this cycle
- busy  out  1  permutation in progress (state RUN)
- round_en  out  1  datapath executes the round for rnd this cycle
- rnd  out  4  current round index
- rc  out  8  round constant for rnd
- first_round  out  1  rnd is the first round of the current permutation, in RUN
- last_round  out  1  rnd == LAST_RND, in RUN
- done  out  1  one-cycle pulse after the last round executes

Behaviour:
- Reset: state IDLE, rnd = P12_START, mode_q = 1, done = 0. Combinational outputs therefore reset to busy = 0, round_en = 0, first_round = 0, last_round = 0, rc = 8'hF0.
- FSM states: IDLE, RUN.
- IDLE:
  - start = 1 -> capture mode into mode_q; load rnd = P12_START if mode = 1, else P8_START; next state RUN.
  - start = 0 -> rnd and mode_q hold.
- RUN:
  - busy = 1.
  - round_en = dp_ready, combinational.
  - dp_ready = 0 -> rnd holds; no round executes (stall of any length).
  - dp_ready = 1 and rnd != LAST_RND -> rnd <= rnd + 1.
  - dp_ready = 1 and rnd == LAST_RND -> rnd holds at LAST_RND; next state IDLE; done <= 1 for exactly one cycle.
- start while in RUN is ignored; there is no queueing.
- Back-to-back: done = 1 and state = IDLE in the same cycle, so start in that cycle is accepted and RUN re-enters on the next cycle. Minimum gap between permutations is 1 cycle.
- rc = {4'hF - i, i}, where i = rnd - P12_START (4-bit, modulo 16).
  - rnd 4..15 gives F0, E1, D2, C3, B4, A5, 96, 87, 78, 69, 5A, 4B.
  - p8 therefore uses B4..4B.
  - rc is purely combinational from rnd, valid in all states.
- first_round = RUN and rnd == (mode_q ? P12_START : P8_START).
- last_round = RUN and rnd == LAST_RND.
- Latency with dp_ready held at 1: start at cycle 0 -> round_en at cycles 1..12 (p12) or 1..8 (p8) -> done at cycle 13 (p12) or 9 (p8).
- Each stall cycle adds exactly one cycle to that latency.
- rnd never wraps; it never exceeds LAST_RND.
  - Defensive case: rnd outside the legal range while in RUN -> next state IDLE, no done pulse.
- Reset asserted mid-permutation:
  - next cycle returns to reset values; done is not pulsed.
  - rst has priority over start.

Test Plan:
- p12, dp_ready = 1: start = 1, mode = 1 at cycle 0 -> rnd 4..15 at cycles 1..12; rc F0..4B; round_en high 12 cycles; first_round only at cycle 1, last_round only at cycle 12; done = 1 only at cycle 13, busy = 0 at cycle 13.
- p8, dp_ready = 1: start = 1, mode = 0 -> rnd 8..15; rc B4, A5, 96, 87, 78, 69, 5A, 4B; round_en high 8 cycles; done at cycle 9.
- Stall: p12 with dp_ready = 0 during cycles 3..5 -> rnd holds 6 and round_en = 0 for those 3 cycles; exactly 12 round_en pulses in total; done at cycle 16.
- Ignored start, then back-to-back: start pulses during RUN -> no effect on rnd or done count; start = 1, mode = 0 in the done cycle of a p12 run -> p8 begins next cycle at rnd = 8, done 9 cycles after acceptance.
- Reset: rst = 1 at p12 round rnd = 9 -> next cycle busy = 0, rnd = 4, rc = F0, done never asserted; a fresh start afterwards completes normally.
- Idle hold: p8 completes, then no start for 5 cycles -> rnd stays 15, round_en = 0, done = 0 throughout.
